mem_access_seq: RTL
===================

MEM_ACCESS_SEQ -- requirements
Module: mem_access_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16: address/data width, a multiple of 8 and at least 16; NB = WIDTH/8 byte lanes.
REQ-002 The block SHALL have parameter TIMEOUT, default 255: maximum wait cycles per memory access; 0 disables the timeout.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port req_valid, input, 1 bit: a request is present.
REQ-006 The block SHALL have port req_ready, output, 1 bit: the block can accept a request.
REQ-007 The block SHALL have port req_op, input, 3 bits: 000 LDR, 001 LDB, 010 LDI, 011 STR, 100 STB, 101 STI; 110 and 111 are illegal.
REQ-008 The block SHALL have ports req_addr and req_wdata, inputs, WIDTH bits each: the effective address and the store data.
REQ-009 The block SHALL have ports mem_read and mem_write, outputs, 1 bit each: memory strobes, held until mem_resp.
REQ-010 The block SHALL have ports mem_addr and mem_wdata, outputs, WIDTH bits each, and mem_byte_en, output, NB bits.
REQ-011 The block SHALL have ports mem_rdata, input, WIDTH bits, and mem_resp, input, 1 bit: memory completion.
REQ-012 The block SHALL have ports rsp_valid, output, 1 bit; rsp_data, output, WIDTH bits; rsp_err, output, 1 bit; busy, output, 1 bit (pipeline stall).

Function
REQ-013 The block SHALL implement the states IDLE, PTR (indirect pointer read), ACC (data access) and RESP.
REQ-014 req_ready SHALL equal 1 only in IDLE; a request is accepted on a rising edge where req_valid && req_ready, and the block latches op, addr and wdata.
REQ-015 On acceptance, LDI/STI SHALL go to PTR; LDR/LDB/STR/STB SHALL go to ACC; illegal ops SHALL go to RESP with rsp_err=1 and no memory strobe.
REQ-016 In PTR: mem_read=1; mem_addr = latched addr with its low log2(NB) bits zeroed; mem_byte_en = all ones.
REQ-017 On mem_resp in PTR, the block SHALL capture mem_rdata as the pointer and move to ACC on the next cycle, using that pointer as the address.
REQ-018 In ACC, loads SHALL assert mem_read and stores SHALL assert mem_write, held stable until the cycle in which mem_resp=1.
REQ-019 Word ops (LDR, LDI, STR, STI) SHALL force the address low bits to 0 and set mem_byte_en to all ones.
REQ-020 Byte ops (LDB, STB): lane k = address[log2(NB)-1:0]; mem_byte_en SHALL be one-hot on k; STB mem_wdata SHALL be req_wdata[7:0] replicated to all lanes.
REQ-021 On mem_resp in ACC, the block SHALL go to RESP. Load data: word = mem_rdata; LDB = lane k of mem_rdata zero-extended to WIDTH. Stores return rsp_data=0.
REQ-022 RESP SHALL last exactly one cycle with rsp_valid=1, then return to IDLE; rsp_data and rsp_err are valid only while rsp_valid=1.
REQ-023 busy SHALL be 1 in PTR, ACC and RESP, and 0 in IDLE.
REQ-024 Latency: LDR with mem_resp in the first ACC cycle SHALL give accept at edge 0, mem_read during cycle 1, rsp_valid during cycle 2. LDI minimum: rsp_valid in cycle 3.
REQ-025 Timeout: a wait counter SHALL clear on entry to PTR or ACC and increment each cycle without mem_resp.
REQ-026 If TIMEOUT>0 and the counter reaches TIMEOUT, the block SHALL deassert the strobes next cycle, enter RESP with rsp_err=1 and rsp_data=0, and skip any remaining access.
REQ-027 mem_resp in IDLE or RESP SHALL be ignored; req_valid outside IDLE SHALL be ignored (not accepted).
REQ-028 mem_addr, mem_wdata and mem_byte_en SHALL be 0 whenever both strobes are 0.
REQ-029 Simultaneous mem_resp and timeout expiry in the same cycle: mem_resp SHALL win (normal completion).

Reset
REQ-030 rst=1 SHALL immediately (asynchronously) force IDLE, req_ready=1, mem_read=mem_write=0, rsp_valid=0, rsp_err=0, busy=0, rsp_data=0 and all latched registers to 0.
REQ-031 Reset mid-operation SHALL abandon the access with no response; the first request after reset release is accepted normally.

Verification
REQ-032 LDR at addr 0x3005, mem_resp in cycle 1, mem_rdata 0xBEEF -> mem_addr 0x3004, byte_en 11, rsp_valid cycle 2, rsp_data 0xBEEF, err 0.
REQ-033 LDB at addr 0x4001, mem_rdata 0xA55A -> byte_en 10, rsp_data 0x00A5; STB at addr 0x4000, wdata 0x1234 -> mem_wdata 0x3434, byte_en 01.
REQ-034 STI at addr 0x2000, pointer 0x5002, wdata 0x00FF, 2 wait cycles per access -> read at 0x2000, then write at 0x5002, rsp_valid once, busy high throughout.
REQ-035 TIMEOUT=4, LDR, mem_resp never asserted -> mem_read high for 4 cycles, then RESP with rsp_err=1 and rsp_data=0, then IDLE.
REQ-036 Illegal op 111 -> no strobe, rsp_valid with err=1 in cycle 1; rst asserted during LDI PTR wait -> strobes low at once, no rsp_valid, next LDR completes normally.

Source files
------------

// File: rtl/mem_access_seq.sv
// Memory access sequencer: runs one load/store request (optionally through an
// indirect pointer read) against a handshaked memory, with per-access timeout.
module mem_access_seq #(
  parameter int WIDTH   = 16,
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [2:0]         req_op,
  input  logic [WIDTH-1:0]   req_addr,
  input  logic [WIDTH-1:0]   req_wdata,
  output logic               mem_read,
  output logic               mem_write,
  output logic [WIDTH-1:0]   mem_addr,
  output logic [WIDTH-1:0]   mem_wdata,
  output logic [WIDTH/8-1:0] mem_byte_en,
  input  logic [WIDTH-1:0]   mem_rdata,
  input  logic               mem_resp,
  output logic               rsp_valid,
  output logic [WIDTH-1:0]   rsp_data,
  output logic               rsp_err,
  output logic               busy
);

  localparam int NB = WIDTH / 8;
  localparam int LB = $clog2(NB);
  localparam int CW = $clog2(TIMEOUT + 2);

  localparam logic [2:0] OP_LDR = 3'b000;
  localparam logic [2:0] OP_LDB = 3'b001;
  localparam logic [2:0] OP_LDI = 3'b010;
  localparam logic [2:0] OP_STR = 3'b011;
  localparam logic [2:0] OP_STB = 3'b100;
  localparam logic [2:0] OP_STI = 3'b101;

  typedef enum logic [1:0] {IDLE, PTR, ACC, RESP} state_t;

  state_t           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             err_q, err_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             is_load, is_byte, expire;
  logic [LB-1:0]    lane_k;
  logic [WIDTH-1:0] addr_aligned, rdata_shifted;

  assign is_load       = (op_q == OP_LDR) || (op_q == OP_LDB) || (op_q == OP_LDI);
  assign is_byte       = (op_q == OP_LDB) || (op_q == OP_STB);
  assign lane_k        = addr_q[LB-1:0];
  assign addr_aligned  = {addr_q[WIDTH-1:LB], {LB{1'b0}}};
  assign rdata_shifted = mem_rdata >> {lane_k, 3'b000};
  // The counter holds cycles already waited, so hitting TIMEOUT-1 here means
  // this is the TIMEOUT-th strobe cycle without a response.
  assign expire        = (TIMEOUT > 0) && (cnt_q == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      data_q  <= data_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    data_d  = data_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          op_d    = req_op;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          data_d  = '0;
          err_d   = 1'b0;
          cnt_d   = '0;
          case (req_op)
            OP_LDI, OP_STI:                 state_d = PTR;
            OP_LDR, OP_LDB, OP_STR, OP_STB: state_d = ACC;
            default: begin
              state_d = RESP;
              err_d   = 1'b1;
            end
          endcase
        end
      end
      PTR: begin
        if (mem_resp) begin
          addr_d  = mem_rdata;
          cnt_d   = '0;
          state_d = ACC;
        end else if (expire) begin
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ACC: begin
        if (mem_resp) begin
          state_d = RESP;
          if (!is_load)     data_d = '0;
          else if (is_byte) data_d = WIDTH'(rdata_shifted[7:0]);
          else              data_d = mem_rdata;
        end else if (expire) begin
          err_d   = 1'b1;
          data_d  = '0;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready   = (state_q == IDLE);
    busy        = (state_q != IDLE);
    rsp_valid   = (state_q == RESP);
    rsp_data    = (state_q == RESP) ? data_q : '0;
    rsp_err     = (state_q == RESP) ? err_q : 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    mem_byte_en = '0;
    if (state_q == PTR) begin
      mem_read    = 1'b1;
      mem_addr    = addr_aligned;
      mem_byte_en = {NB{1'b1}};
    end else if (state_q == ACC) begin
      mem_read  = is_load;
      mem_write = !is_load;
      if (is_byte) begin
        mem_addr    = addr_q;
        mem_byte_en = NB'(1) << lane_k;
        if (!is_load) mem_wdata = {NB{wdata_q[7:0]}};
      end else begin
        mem_addr    = addr_aligned;
        mem_byte_en = {NB{1'b1}};
        if (!is_load) mem_wdata = wdata_q;
      end
    end
  end

endmodule
